// File: rtl/arp_cache_lookup.sv
// ARP cache: ENTRIES x {valid, IP, MAC} table with register-style access, a handshaked
// 2-cycle next-hop lookup (lowest index wins), per-entry aging and hit/miss counters.
module arp_cache_lookup #(
  parameter int ENTRIES     = 32,
  parameter int IDX_WIDTH   = 5,
  parameter int AGE_WIDTH   = 16,
  parameter int ENTRY_WIDTH = 96
) (
  input  logic                   AXI_ACLK,
  input  logic                   AXI_RESETN,
  input  logic                   tbl_wr_req,
  input  logic [IDX_WIDTH-1:0]   tbl_wr_addr,
  input  logic [ENTRY_WIDTH-1:0] tbl_wr_data,
  output logic                   tbl_wr_ack,
  input  logic                   tbl_rd_req,
  input  logic [IDX_WIDTH-1:0]   tbl_rd_addr,
  output logic [ENTRY_WIDTH-1:0] tbl_rd_data,
  output logic                   tbl_rd_ack,
  input  logic                   lookup_valid,
  output logic                   lookup_ready,
  input  logic [31:0]            lookup_ip,
  input  logic [31:0]            lookup_oq,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_hit,
  output logic [47:0]            result_mac,
  output logic [IDX_WIDTH-1:0]   result_index,
  output logic [31:0]            result_oq,
  input  logic                   age_tick,
  input  logic [AGE_WIDTH-1:0]   age_limit,
  input  logic                   clear_counters,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMPARE = 2'd1, S_RESULT = 2'd2} state_t;

  state_t                 r_state;
  logic [ENTRIES-1:0]     r_valid;
  logic [31:0]            r_ip  [ENTRIES];
  logic [47:0]            r_mac [ENTRIES];
  logic [AGE_WIDTH-1:0]   r_age [ENTRIES];

  logic                   r_lookup_ready;
  logic [31:0]            r_key_ip;
  logic [31:0]            r_key_oq;
  logic                   r_result_valid;
  logic                   r_result_hit;
  logic [47:0]            r_result_mac;
  logic [IDX_WIDTH-1:0]   r_result_index;
  logic [31:0]            r_result_oq;
  logic [31:0]            r_hit_count;
  logic [31:0]            r_miss_count;
  logic                   r_wr_ack;
  logic                   r_rd_ack;
  logic [ENTRY_WIDTH-1:0] r_rd_data;

  logic [ENTRIES-1:0]     w_match;
  logic                   w_hit;
  logic [IDX_WIDTH-1:0]   w_idx;
  logic [AGE_WIDTH-1:0]   w_age_inc [ENTRIES];
  logic                   w_aging;
  logic                   w_done;
  logic                   w_unused_rsvd;

  assign w_aging       = age_tick && (age_limit != '0);
  assign w_done        = (r_state == S_COMPARE);
  assign w_unused_rsvd = ^tbl_wr_data[ENTRY_WIDTH-2:80];

  always_comb begin
    w_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_match[i] = r_valid[i] && (r_ip[i] == r_key_ip);
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_age_inc[i] = (&r_age[i]) ? r_age[i] : r_age[i] + 1'b1;
    end
  end

  // Per-entry precedence: table write, then hit refresh, then aging tick.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ip[i]  <= '0;
        r_mac[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (tbl_wr_req && (tbl_wr_addr == IDX_WIDTH'(i))) begin
          r_valid[i] <= tbl_wr_data[ENTRY_WIDTH-1];
          r_mac[i]   <= tbl_wr_data[79:32];
          r_ip[i]    <= tbl_wr_data[31:0];
          r_age[i]   <= '0;
        end else if (w_done && w_hit && (w_idx == IDX_WIDTH'(i))) begin
          r_age[i] <= '0;
        end else if (w_aging && r_valid[i]) begin
          r_age[i] <= w_age_inc[i];
          if (w_age_inc[i] >= age_limit) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wr_ack <= tbl_wr_req;
      r_rd_ack <= tbl_rd_req;
      if (tbl_rd_req) begin
        r_rd_data <= {r_valid[tbl_rd_addr], {(ENTRY_WIDTH-81){1'b0}},
                      r_mac[tbl_rd_addr], r_ip[tbl_rd_addr]};
      end
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_state        <= S_IDLE;
      r_lookup_ready <= 1'b0;
      r_key_ip       <= '0;
      r_key_oq       <= '0;
      r_result_valid <= 1'b0;
      r_result_hit   <= 1'b0;
      r_result_mac   <= '0;
      r_result_index <= '0;
      r_result_oq    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lookup_ready <= 1'b1;
          if (lookup_valid && r_lookup_ready) begin
            r_key_ip       <= lookup_ip;
            r_key_oq       <= lookup_oq;
            r_lookup_ready <= 1'b0;
            r_state        <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_result_valid <= 1'b1;
          r_result_hit   <= w_hit;
          r_result_mac   <= w_hit ? r_mac[w_idx] : 48'd0;
          r_result_index <= w_idx;
          r_result_oq    <= r_key_oq;
          r_state        <= S_RESULT;
        end
        S_RESULT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_lookup_ready <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (clear_counters) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_done) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign tbl_wr_ack   = r_wr_ack;
  assign tbl_rd_ack   = r_rd_ack;
  assign tbl_rd_data  = r_rd_data;
  assign lookup_ready = r_lookup_ready;
  assign result_valid = r_result_valid;
  assign result_hit   = r_result_hit;
  assign result_mac   = r_result_mac;
  assign result_index = r_result_index;
  assign result_oq    = r_result_oq;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

endmodule

// File: tb/tb_arp_cache_lookup.sv
// Directed and randomized checks of arp_cache_lookup against an array-based cache model.
module tb_arp_cache_lookup;
  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        wr_req = 0, rd_req = 0, lk_valid = 0, res_ready = 0, age_tick = 0, clr = 0;
  logic [4:0]  wr_addr = 0, rd_addr = 0;
  logic [95:0] wr_data = 0;
  logic [31:0] lk_ip = 0, lk_oq = 0;
  logic [15:0] age_limit = 0;
  logic        wr_ack, rd_ack, lk_ready, res_valid, res_hit;
  logic [95:0] rd_data;
  logic [47:0] res_mac;
  logic [4:0]  res_index;
  logic [31:0] res_oq, hit_count, miss_count;

  int n_checks = 0;
  int n_fail = 0;

  bit          m_valid [N];
  logic [31:0] m_ip    [N];
  logic [47:0] m_mac   [N];
  int          m_age   [N];
  logic [31:0] e_hits = 0;
  logic [31:0] e_miss = 0;

  arp_cache_lookup dut (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n),
    .tbl_wr_req(wr_req), .tbl_wr_addr(wr_addr), .tbl_wr_data(wr_data), .tbl_wr_ack(wr_ack),
    .tbl_rd_req(rd_req), .tbl_rd_addr(rd_addr), .tbl_rd_data(rd_data), .tbl_rd_ack(rd_ack),
    .lookup_valid(lk_valid), .lookup_ready(lk_ready), .lookup_ip(lk_ip), .lookup_oq(lk_oq),
    .result_valid(res_valid), .result_ready(res_ready), .result_hit(res_hit),
    .result_mac(res_mac), .result_index(res_index), .result_oq(res_oq),
    .age_tick(age_tick), .age_limit(age_limit), .clear_counters(clr),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [95:0] mk(input logic v, input logic [47:0] mac, input logic [31:0] ip);
    return {v, 15'h0, mac, ip};
  endfunction

  function automatic logic [95:0] mword(input int i);
    return {m_valid[i], 15'h0, m_mac[i], m_ip[i]};
  endfunction

  function automatic int find(input logic [31:0] ip);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_ip[i] == ip) return i;
    return -1;
  endfunction

  task automatic model_write(input int idx, input logic [95:0] d);
    m_valid[idx] = d[95];
    m_mac[idx]   = d[79:32];
    m_ip[idx]    = d[31:0];
    m_age[idx]   = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_ip[i] = 0; m_mac[i] = 0; m_age[i] = 0;
    end
    e_hits = 0;
    e_miss = 0;
  endtask

  task automatic wr(input int idx, input logic [95:0] d);
    wr_req = 1; wr_addr = idx[4:0]; wr_data = d;
    step();
    wr_req = 0;
    model_write(idx, d);
    chk("wr_ack", wr_ack, 1);
  endtask

  task automatic rd_chk(input int idx);
    rd_req = 1; rd_addr = idx[4:0];
    step();
    rd_req = 0;
    chk("rd_ack", rd_ack, 1);
    chk($sformatf("rd_data[%0d]", idx), rd_data, mword(idx));
  endtask

  task automatic tick();
    age_tick = 1;
    step();
    age_tick = 0;
    if (age_limit != 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i]) begin
          m_age[i] = (m_age[i] >= 65535) ? 65535 : m_age[i] + 1;
          if (m_age[i] >= int'(age_limit)) m_valid[i] = 0;
        end
      end
    end
  endtask

  // wph: 0 no side write, 1 write in the accept cycle, 2 write in the compare cycle.
  task automatic lookup(input logic [31:0] ip, input logic [31:0] oq, input int stall,
                        input int wph, input int widx, input logic [95:0] wdat);
    int e;
    logic [47:0] emac;
    logic [4:0]  eidx;
    chk("lookup_ready_idle", lk_ready, 1);
    lk_valid = 1; lk_ip = ip; lk_oq = oq;
    if (wph == 1) begin
      wr_req = 1; wr_addr = widx[4:0]; wr_data = wdat;
      model_write(widx, wdat);
    end
    e = find(ip);
    step();
    lk_valid = 0; wr_req = 0;
    if (wph == 2) begin
      wr_req = 1; wr_addr = widx[4:0]; wr_data = wdat;
    end
    chk("accept_ready_low", lk_ready, 0);
    chk("no_early_result", res_valid, 0);
    step();
    wr_req = 0;
    if (wph == 2) model_write(widx, wdat);
    if (e >= 0) begin
      m_age[e] = 0;
      e_hits = e_hits + 1;
    end else begin
      e_miss = e_miss + 1;
    end
    emac = (e >= 0) ? m_mac[e] : 48'd0;
    eidx = (e >= 0) ? e[4:0] : 5'd0;
    for (int k = 0; k <= stall; k++) begin
      chk("result_valid", res_valid, 1);
      chk("result_hit", res_hit, (e >= 0));
      chk("result_mac", res_mac, emac);
      chk("result_index", res_index, eidx);
      chk("result_oq", res_oq, oq);
      chk("ready_in_result", lk_ready, 0);
      chk("hit_count", hit_count, e_hits);
      chk("miss_count", miss_count, e_miss);
      if (k < stall) step();
    end
    res_ready = 1;
    step();
    res_ready = 0;
    chk("result_released", res_valid, 0);
    chk("ready_after_result", lk_ready, 1);
  endtask

  initial begin
    int op, idx;
    logic [63:0] r64;
    logic [31:0] ipr;
    logic [95:0] old;

    model_clear();
    #2 rst_n = 0;
    #1;
    chk("rst_lookup_ready", lk_ready, 0);
    chk("rst_result_valid", res_valid, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("ready_after_reset", lk_ready, 1);
    chk("wr_ack_idle", wr_ack, 0);

    wr(3, mk(1, 48'h001122334455, 32'h0A000101));
    lookup(32'h0A000101, 32'h04, 0, 0, 0, 0);
    chk("first_hit_count", hit_count, 1);

    lookup(32'h0A000909, 32'h11, 0, 0, 0, 0);
    wr(5, mk(0, 48'hAAAAAAAAAAAA, 32'h0A000909));
    lookup(32'h0A000909, 32'h12, 0, 0, 0, 0);

    wr(7, mk(1, 48'h070707070707, 32'hC0A80001));
    wr(2, mk(1, 48'h020202020202, 32'hC0A80001));
    lookup(32'hC0A80001, 32'h1, 0, 0, 0, 0);
    wr(2, mk(0, 48'h020202020202, 32'hC0A80001));
    lookup(32'hC0A80001, 32'h2, 0, 0, 0, 0);
    lookup(32'hC0A80001, 32'h3, 5, 0, 0, 0);

    age_limit = 16'd3;
    wr(9, mk(1, 48'h090909090909, 32'h0A000009));
    tick(); tick(); tick();
    rd_chk(9);
    chk("aged_out_valid", rd_data[95], 0);
    lookup(32'h0A000009, 32'h9, 0, 0, 0, 0);
    wr(9, mk(1, 48'h090909090909, 32'h0A000009));
    tick(); tick();
    lookup(32'h0A000009, 32'h9, 0, 0, 0, 0);
    tick(); tick();
    rd_chk(9);
    chk("refreshed_valid", rd_data[95], 1);
    lookup(32'h0A000009, 32'hA, 0, 0, 0, 0);
    age_limit = 16'd0;

    wr(3, mk(1, 48'h001122334455, 32'h0A000101));
    old = mword(3);
    wr_req = 1; wr_addr = 5'd3; wr_data = {1'b1, 15'h7FFF, 48'hDEADBEEF0001, 32'h0A000303};
    rd_req = 1; rd_addr = 5'd3;
    step();
    wr_req = 0; rd_req = 0;
    chk("same_cycle_rd_old", rd_data, old);
    chk("same_cycle_wr_ack", wr_ack, 1);
    model_write(3, {1'b1, 15'h7FFF, 48'hDEADBEEF0001, 32'h0A000303});
    rd_chk(3);
    chk("reserved_zero", rd_data[94:80], 0);

    lookup(32'h0A001414, 32'h20, 0, 1, 20, mk(1, 48'h141414141414, 32'h0A001414));
    lookup(32'h0A001515, 32'h21, 0, 2, 21, mk(1, 48'h151515151515, 32'h0A001515));
    lookup(32'h0A001515, 32'h22, 0, 0, 0, 0);

    clr = 1;
    step();
    clr = 0;
    e_hits = 0; e_miss = 0;
    chk("clear_hits", hit_count, 0);
    chk("clear_misses", miss_count, 0);

    age_limit = 16'd5;
    for (int it = 0; it < 120; it++) begin
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, N - 1);
      ipr = 32'h0A000000 | 32'($urandom_range(0, 5));
      r64 = {$urandom, $urandom};
      if (op < 3)      wr(idx, mk($urandom_range(0, 3) != 0, r64[47:0], ipr));
      else if (op < 7) lookup(ipr, $urandom, $urandom_range(0, 2), 0, 0, 0);
      else if (op < 9) tick();
      else             rd_chk(idx);
    end

    chk("lookup_ready_pre_rst", lk_ready, 1);
    lk_valid = 1; lk_ip = 32'h0A000001; lk_oq = 32'h5;
    step();
    lk_valid = 0;
    step();
    chk("midlookup_result_valid", res_valid, 1);
    rst_n = 0;
    #1;
    chk("async_rst_result_valid", res_valid, 0);
    chk("async_rst_ready", lk_ready, 0);
    chk("async_rst_hits", hit_count, 0);
    chk("async_rst_misses", miss_count, 0);
    @(negedge clk);
    rst_n = 1;
    model_clear();
    step();
    chk("ready_after_rst2", lk_ready, 1);
    chk("no_stale_result", res_valid, 0);
    for (int i = 0; i < N; i++) rd_chk(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
